// File: rtl/adder_arb.sv
// adder_arb: round-robin arbiter/sequencer sharing one W-bit adder among NREQ
// requesters. The FSM grants one requester and latches its operands. It holds
// Adder_valid until the adder acks, then returns the registered result with a
// one-cycle ack. It waits for the granted requester to drop its request before
// arbitrating again.
// Optional feature: define ADDER_ARB_TIMEOUT_EN to enable an adder-ack watchdog.
// When it fires, the requester is acked with result 0, carry 0 and exc 2'b11.
module adder_arb #(
  parameter int NREQ    = 2,
  parameter int W       = 25,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RSTK,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_datain1,
  input  logic [NREQ*W-1:0] req_datain2,
  output logic [NREQ-1:0]   req_ack,
  output logic [W-1:0]      req_dataout,
  output logic              req_carryout,
  output logic [1:0]        req_exc,
  output logic [W-1:0]      Adder_datain1,
  output logic [W-1:0]      Adder_datain2,
  output logic              Adder_valid,
  input  logic [W-1:0]      Adder_dataout,
  input  logic              Adder_carryout,
  input  logic [1:0]        Adder_Exc,
  input  logic              Adder_ack,
  output logic              busy,
  output logic [2:0]        grant_id
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_busy;
  logic [IW-1:0]   r_gnt;
  logic [IW-1:0]   r_rr_ptr;
  logic [W-1:0]    r_op_a;
  logic [W-1:0]    r_op_b;
  logic [W-1:0]    r_res;
  logic            r_carry;
  logic [1:0]      r_exc;

  logic [NREQ-1:0] w_mask;
  logic [NREQ-1:0] w_hi;
  logic            w_any;
  logic            w_hi_any;
  logic [IW-1:0]   w_hi_idx;
  logic [IW-1:0]   w_lo_idx;
  logic [IW-1:0]   w_sel;
  logic [IW-1:0]   w_rr_next;
  logic            w_ld_grant;
  logic            w_ld_result;
  logic            w_timeout;
  logic            w_tmo_hit;

  // Round-robin split: requests at or above rr_ptr win over the wrapped-around ones.
  // The ack is a decode of RESP and the granted index.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign w_mask[gi]  = (32'(gi) >= 32'(r_rr_ptr));
      assign req_ack[gi] = (r_state == S_RESP) && (r_gnt == IW'(gi));
    end
  endgenerate

  assign w_hi     = req_valid & w_mask;
  assign w_any    = |req_valid;
  assign w_hi_any = |w_hi;

  // Lowest set index of the upper (unwrapped) group and of the full request vector.
  always_comb begin
    w_hi_idx = '0;
    w_lo_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) w_lo_idx = IW'(i);
      if (w_hi[i])      w_hi_idx = IW'(i);
    end
  end

  assign w_sel     = w_hi_any ? w_hi_idx : w_lo_idx;
  assign w_rr_next = (w_sel == IW'(NREQ - 1)) ? '0 : w_sel + IW'(1);

`ifdef ADDER_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_tmo_cnt;

  // Count ack-less ISSUE cycles; cleared whenever a new transaction is granted.
  always_ff @(posedge CLK or posedge RSTK) begin
    if (RSTK) begin
      r_tmo_cnt <= '0;
    end else if (w_ld_grant) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_ISSUE) && !Adder_ack) begin
      r_tmo_cnt <= r_tmo_cnt + CW'(1);
    end
  end

  // Fires on the TIMEOUT-th ISSUE cycle without an ack.
  assign w_tmo_hit = (r_state == S_ISSUE) && (r_tmo_cnt == CW'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_tmo_hit        = 1'b0;
`endif

  // Next-state logic and load strobes; Adder_ack only matters in ISSUE.
  always_comb begin
    w_state_next = r_state;
    w_ld_grant   = 1'b0;
    w_ld_result  = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_next = S_ISSUE;
          w_ld_grant   = 1'b1;
        end
      end
      S_ISSUE: begin
        if (Adder_ack) begin
          w_state_next = S_RESP;
          w_ld_result  = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_next = S_RESP;
          w_timeout    = 1'b1;
        end
      end
      S_RESP: begin
        w_state_next = S_HOLD;
      end
      S_HOLD: begin
        if (!req_valid[r_gnt]) w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State, grant, latched operands and held results.
  always_ff @(posedge CLK or posedge RSTK) begin
    if (RSTK) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_res    <= '0;
      r_carry  <= 1'b0;
      r_exc    <= 2'b00;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != S_IDLE);
      if (w_ld_grant) begin
        r_gnt    <= w_sel;
        r_rr_ptr <= w_rr_next;
        r_op_a   <= req_datain1[w_sel*W +: W];
        r_op_b   <= req_datain2[w_sel*W +: W];
      end
      if (w_ld_result) begin
        r_res   <= Adder_dataout;
        r_carry <= Adder_carryout;
        r_exc   <= Adder_Exc;
      end else if (w_timeout) begin
        r_res   <= '0;
        r_carry <= 1'b0;
        r_exc   <= 2'b11;
      end
    end
  end

  assign Adder_valid   = (r_state == S_ISSUE);
  assign Adder_datain1 = r_op_a;
  assign Adder_datain2 = r_op_b;
  assign req_dataout   = r_res;
  assign req_carryout  = r_carry;
  assign req_exc       = r_exc;
  assign busy          = r_busy;
  assign grant_id      = 3'(r_gnt);

endmodule

// File: tb/tb_adder_arb.sv
// Testbench for adder_arb: directed scenarios plus randomized concurrent
// requesters. Expected results are pushed per requester on issue and
// consumed by a negedge monitor whenever the DUT pulses req_ack.
module tb_adder_arb;

  localparam int NREQ    = 2;
  localparam int W       = 25;
  localparam int TIMEOUT = 16;

  logic              CLK = 1'b0;
  logic              RSTK;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_datain1;
  logic [NREQ*W-1:0] req_datain2;
  logic [NREQ-1:0]   req_ack;
  logic [W-1:0]      req_dataout;
  logic              req_carryout;
  logic [1:0]        req_exc;
  logic [W-1:0]      Adder_datain1;
  logic [W-1:0]      Adder_datain2;
  logic              Adder_valid;
  logic [W-1:0]      Adder_dataout;
  logic              Adder_carryout;
  logic [1:0]        Adder_Exc;
  logic              Adder_ack;
  logic              busy;
  logic [2:0]        grant_id;

  adder_arb #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RSTK(RSTK),
    .req_valid(req_valid), .req_datain1(req_datain1), .req_datain2(req_datain2),
    .req_ack(req_ack), .req_dataout(req_dataout), .req_carryout(req_carryout), .req_exc(req_exc),
    .Adder_datain1(Adder_datain1), .Adder_datain2(Adder_datain2), .Adder_valid(Adder_valid),
    .Adder_dataout(Adder_dataout), .Adder_carryout(Adder_carryout), .Adder_Exc(Adder_Exc),
    .Adder_ack(Adder_ack), .busy(busy), .grant_id(grant_id)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    int           id;
    logic [W+2:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   ack_log[$];
  int   wait_cnt[NREQ];
  bit   pending[NREQ];
  int   checks   = 0;
  int   failures = 0;

  int   ad_delay = 1;
  bit   ad_rand  = 1'b0;
  bit   spur_en  = 1'b0;

  // Reference adder: {exc, carry, sum}; exc is an arbitrary operand function
  // so that pass-through of every field is observable.
  function automatic logic [W+2:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {a[1:0] ^ b[1:0], s};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic req_go(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W+2:0] e);
    exp_t x;
    x.id = i;
    x.v  = e;
    exp_q.push_back(x);
    pending[i] = 1'b1;
    req_datain1[i*W +: W] = a;
    req_datain2[i*W +: W] = b;
    req_valid[i] = 1'b1;
    $display("issue req=%0d a=%0h b=%0h exp=%0h t=%0t", i, a, b, e, $time);
  endtask

  task automatic go(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_go(i, a, b, ref_add(a, b));
  endtask

  // Counts rising edges from the call until req_ack[i] is seen; -1 on timeout.
  task automatic wait_ack(input int i, output int n);
    n = 0;
    forever begin
      @(posedge CLK);
      @(negedge CLK);
      n++;
      if (req_ack[i]) break;
      if (n >= 400) begin
        checks++;
        failures++;
        $display("FAIL ack_timeout req=%0d got=none exp=ack", i);
        n = -1;
        break;
      end
    end
    pending[i] = 1'b0;
  endtask

  task automatic chk_order(input int e0, input int e1, input int e2, input int len);
    chk("order_len", ack_log.size(), len);
    if (ack_log.size() > 0) chk("order0", ack_log[0], e0);
    if (ack_log.size() > 1) chk("order1", ack_log[1], e1);
    if (ack_log.size() > 2 && len > 2) chk("order2", ack_log[2], e2);
  endtask

  task automatic rand_req(input int i, input int n);
    logic [W-1:0] a;
    logic [W-1:0] b;
    int lat;
    repeat (n) begin
      repeat ($urandom_range(0, 3)) tick();
      a = W'($urandom);
      b = W'($urandom);
      go(i, a, b);
      wait_ack(i, lat);
      repeat ($urandom_range(0, 3)) tick();
      req_valid[i] = 1'b0;
      repeat (2) tick();
    end
  endtask

  // Adder model: acks the ad_delay-th ISSUE cycle (0 = same cycle); puts
  // garbage on the result bus otherwise and may pulse stray acks when idle.
  initial begin
    int ad_cnt;
    int ad_cur;
    ad_cnt = 0;
    ad_cur = 0;
    Adder_ack = 1'b0;
    {Adder_Exc, Adder_carryout, Adder_dataout} = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (Adder_valid) begin
        if (ad_cnt == 0) ad_cur = ad_rand ? int'($urandom_range(0, 4)) : ad_delay;
        if (ad_cur >= 0 && ad_cnt == ad_cur) begin
          Adder_ack = 1'b1;
          {Adder_Exc, Adder_carryout, Adder_dataout} = ref_add(Adder_datain1, Adder_datain2);
        end else begin
          Adder_ack = 1'b0;
          {Adder_Exc, Adder_carryout, Adder_dataout} = (W+3)'({$urandom, $urandom});
        end
        ad_cnt++;
      end else begin
        ad_cnt = 0;
        Adder_ack = spur_en && ($urandom_range(0, 3) == 0);
        {Adder_Exc, Adder_carryout, Adder_dataout} = (W+3)'({$urandom, $urandom});
      end
    end
  end

  // Monitor: scoreboard pop on every ack, result-hold check otherwise,
  // and a bound on how many other grants a pending requester sees.
  initial begin
    logic [W+2:0] last_res;
    logic [W+2:0] got;
    int id;
    bit found;
    last_res = '0;
    forever begin
      @(negedge CLK);
      if (RSTK) begin
        last_res = '0;
        chk("reset_quiet", {req_ack, Adder_valid}, 0);
        continue;
      end
      got = {req_exc, req_carryout, req_dataout};
      if (req_ack != '0) begin
        chk("ack_onehot", $onehot(req_ack), 1);
        id = 0;
        for (int k = 0; k < NREQ; k++) if (req_ack[k]) id = k;
        chk("valid_in_resp", Adder_valid, 0);
        chk("grant_id", grant_id, id);
        found = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
          if (!found && exp_q[k].id == id) begin
            found = 1'b1;
            chk("result", got, exp_q[k].v);
            last_res = exp_q[k].v;
            exp_q.delete(k);
          end
        end
        if (!found) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack req=%0d got=%0h exp=no_ack t=%0t", id, got, $time);
        end
        $display("ack req=%0d result=%0h t=%0t", id, got, $time);
        ack_log.push_back(id);
        for (int k = 0; k < NREQ; k++) begin
          if (k != id && pending[k]) begin
            wait_cnt[k]++;
            chk("fairness", wait_cnt[k] <= NREQ, 1);
          end
        end
        wait_cnt[id] = 0;
      end else begin
        chk("result_hold", got, last_res);
      end
    end
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n;
    RSTK = 1'b0;
    req_valid = '0;
    req_datain1 = '0;
    req_datain2 = '0;
    foreach (pending[k]) begin
      pending[k] = 1'b0;
      wait_cnt[k] = 0;
    end

    // Reset values.
    #1 RSTK = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req_ack", req_ack, 0);
    chk("rst_adder_valid", Adder_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_dataout", req_dataout, 0);
    chk("rst_exc", req_exc, 0);
    chk("rst_carry", req_carryout, 0);
    chk("rst_adder_a", Adder_datain1, 0);
    chk("rst_adder_b", Adder_datain2, 0);
    RSTK = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Simultaneous requests, then re-request of 0: order 0, 1, 0.
    ack_log.delete();
    ad_delay = 1;
    go(0, 25'h0000011, 25'h0000022);
    go(1, 25'h1000000, 25'h1000001);
    wait_ack(0, n);
    req_valid[0] = 1'b0;
    repeat (2) tick();
    go(0, 25'h0ABCDEF, 25'h0123456);
    wait_ack(1, n);
    req_valid[1] = 1'b0;
    wait_ack(0, n);
    req_valid[0] = 1'b0;
    repeat (2) tick();
    chk_order(0, 1, 0, 3);

    // Single request, adder acks on the 4th ISSUE cycle.
    ad_delay = 3;
    go(0, 25'h0000005, 25'h0000003);
    wait_ack(0, n);
    chk("lat_single", n, 5);
    chk("single_data", req_dataout, 25'h0000008);
    req_valid[0] = 1'b0;
    repeat (2) tick();
    chk("busy_after_hold", busy, 0);

    // Same-cycle adder ack: minimum latency and exc/carry pass-through.
    ad_delay = 0;
    go(1, 25'h1FFFFFF, 25'h0000002);
    wait_ack(1, n);
    chk("lat_min", n, 2);
    chk("exc_pass", req_exc, 2'b01);
    chk("carry_pass", req_carryout, 1);
    req_valid[1] = 1'b0;
    repeat (2) tick();

    // Requester 0 holds valid 3 cycles after its ack while 1 is pending.
    ack_log.delete();
    ad_delay = 1;
    go(0, 25'h0000100, 25'h0000200);
    tick();
    go(1, 25'h0000300, 25'h0000400);
    wait_ack(0, n);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_busy", busy, 1);
      chk("hold_no_valid", Adder_valid, 0);
      chk("hold_no_ack", req_ack, 0);
    end
    req_valid[0] = 1'b0;
    wait_ack(1, n);
    req_valid[1] = 1'b0;
    repeat (2) tick();
    chk_order(0, 1, 0, 2);

    // Reset mid-ISSUE: transaction abandoned, stray acks ignored, rr_ptr back to 0.
    ad_delay = -1;
    go(0, 25'h0000777, 25'h0000001);
    repeat (2) tick();
    chk("issue_valid", Adder_valid, 1);
    #1 RSTK = 1'b1;
    #1;
    chk("async_valid_drop", Adder_valid, 0);
    chk("async_busy_drop", busy, 0);
    chk("async_ack_low", req_ack, 0);
    spur_en = 1'b1;
    req_valid = '0;
    exp_q.delete();
    foreach (pending[k]) begin
      pending[k] = 1'b0;
      wait_cnt[k] = 0;
    end
    @(negedge CLK);
    @(posedge CLK);
    #2 RSTK = 1'b0;
    repeat (6) tick();
    spur_en = 1'b0;
    ad_delay = 1;
    ack_log.delete();
    go(0, 25'h0000010, 25'h0000020);
    go(1, 25'h0000030, 25'h0000040);
    wait_ack(0, n);
    req_valid[0] = 1'b0;
    wait_ack(1, n);
    chk("post_rst_r1_data", req_dataout, 25'h0000070);
    req_valid[1] = 1'b0;
    repeat (2) tick();
    chk_order(0, 1, 0, 2);

    // Randomized concurrent requesters with random adder latency and stray acks.
    ad_rand = 1'b1;
    spur_en = 1'b1;
    for (int r = 0; r < NREQ; r++) begin
      automatic int ri = r;
      fork
        rand_req(ri, 30);
      join_none
    end
    wait fork;
    ad_rand = 1'b0;
    spur_en = 1'b0;
    repeat (3) tick();

`ifdef ADDER_ARB_TIMEOUT_EN
    // Adder never acks: watchdog response, later stray acks ignored.
    ad_delay = -1;
    spur_en = 1'b1;
    req_go(0, 25'h0000009, 25'h0000009, {2'b11, {(W+1){1'b0}}});
    wait_ack(0, n);
    chk("tmo_latency", n, TIMEOUT + 1);
    chk("tmo_exc", req_exc, 2'b11);
    chk("tmo_data", req_dataout, 0);
    req_valid[0] = 1'b0;
    repeat (8) tick();
    spur_en = 1'b0;
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
